// File: rtl/gpreg_issue_decoder.sv
// Instruction decoder feeding the general-purpose register file: accepts 32-bit
// words on a valid/ready stream and presents one register-file command per instruction.
module gpreg_issue_decoder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr_data,
    output logic              instr_ready,
    input  logic              hold,
    output logic [2:0]        SelX,
    output logic [2:0]        SelY,
    output logic [2:0]        SelZ,
    output logic [1:0]        MemInstruction,
    output logic [DATA_W-1:0] MemData,
    output logic              issue,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IMM   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LDS = 4'h2,
        OP_RD  = 4'h3
    } opcode_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_WRITE = 2'b11
    } cmd_t;

    state_t            state;
    cmd_t              code;
    logic              accept;
    logic [3:0]        opcode;
    logic [2:0]        fld_z;
    logic [2:0]        fld_x;
    logic [2:0]        fld_y;
    logic [DATA_W-1:0] imm_sext;

    assign opcode   = instr_data[31:28];
    assign fld_z    = instr_data[26:24];
    assign fld_x    = instr_data[23:21];
    assign fld_y    = instr_data[20:18];
    assign imm_sext = {{(DATA_W-16){instr_data[15]}}, instr_data[15:0]};

    assign instr_ready = (state != ISSUE);
    assign accept      = instr_valid & instr_ready;

    // The write command is exposed only during the single unheld ISSUE cycle.
    assign issue          = (state == ISSUE) && !hold;
    assign MemInstruction = issue ? code : CMD_NONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            code        <= CMD_NONE;
            SelX        <= '0;
            SelY        <= '0;
            SelZ        <= '0;
            MemData     <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        case (opcode)
                            OP_NOP: begin
                                code <= CMD_NONE;
                            end
                            OP_LDI: begin
                                SelZ  <= fld_z;
                                code  <= CMD_WRITE;
                                state <= IMM;
                            end
                            OP_LDS: begin
                                SelZ    <= fld_z;
                                MemData <= imm_sext;
                                code    <= CMD_WRITE;
                            end
                            OP_RD: begin
                                SelX <= fld_x;
                                SelY <= fld_y;
                                code <= CMD_NONE;
                            end
                            default: begin
                                illegal <= 1'b1;
                                code    <= CMD_NONE;
                            end
                        endcase
                    end
                end
                IMM: begin
                    // Second LDI word is raw data, never decoded.
                    if (accept) begin
                        MemData <= DATA_W'(instr_data);
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpreg_issue_decoder.sv
// Randomized bench for gpreg_issue_decoder with a transaction-level reference model;
// a second instance with a 4-bit counter exercises counter wrap cheaply.
module tb_gpreg_issue_decoder;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic [31:0]       instr_data;
    logic              hold;
    logic              instr_ready;
    logic [2:0]        SelX, SelY, SelZ;
    logic [1:0]        MemInstruction;
    logic [DATA_W-1:0] MemData;
    logic              issue;
    logic              illegal;
    logic [CNT_W-1:0]  instr_count;

    logic              s_ready, s_issue, s_illegal;
    logic [2:0]        s_x, s_y, s_z;
    logic [1:0]        s_mi;
    logic [DATA_W-1:0] s_data;
    logic [3:0]        s_count;

    always #5 clk = ~clk;

    gpreg_issue_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(instr_ready), .hold(hold), .SelX(SelX), .SelY(SelY), .SelZ(SelZ),
        .MemInstruction(MemInstruction), .MemData(MemData), .issue(issue),
        .illegal(illegal), .instr_count(instr_count)
    );

    gpreg_issue_decoder #(.DATA_W(DATA_W), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(s_ready), .hold(hold), .SelX(s_x), .SelY(s_y), .SelZ(s_z),
        .MemInstruction(s_mi), .MemData(s_data), .issue(s_issue),
        .illegal(s_illegal), .instr_count(s_count)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: architectural view of the register-file command stream.
    logic [2:0]  m_x, m_y, m_z;
    logic [31:0] m_data;
    logic [1:0]  m_code;
    logic        m_ill;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_z = 0; m_data = 0; m_code = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, instr_ready, 1);
        check({tag, "_issue"}, issue, 0);
        check({tag, "_mi"}, MemInstruction, 0);
        check({tag, "_selx"}, SelX, 0);
        check({tag, "_sely"}, SelY, 0);
        check({tag, "_selz"}, SelZ, 0);
        check({tag, "_data"}, MemData, 0);
        check({tag, "_ill"}, illegal, 0);
        check({tag, "_cnt"}, instr_count, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0; instr_valid = 1'b0; hold = 1'b0; instr_data = '0;
        #1;
        model_reset();
        check_cleared("reset");
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            hold = 1'($urandom_range(0, 1));
            #1;
            check("idle_issue", issue, 0);
            check("idle_mi", MemInstruction, 0);
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] imm,
                        input int unsigned gap, input int unsigned holds);
        logic [3:0] op;
        logic [15:0] i16;
        op  = w[31:28];
        i16 = w[15:0];
        check("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr_data  = w;
        hold = 1'($urandom_range(0, 1));
        tick();
        instr_valid = 1'b0;
        instr_data  = $urandom;
        case (op)
            4'h0: m_code = 2'b00;
            4'h1: begin m_z = w[26:24]; m_code = 2'b11; end
            4'h2: begin
                m_z = w[26:24];
                m_data = (i16 >= 16'h8000) ? 32'hFFFF0000 + 32'(i16) : 32'(i16);
                m_code = 2'b11;
            end
            4'h3: begin m_x = w[23:21]; m_y = w[20:18]; m_code = 2'b00; end
            default: begin m_ill = 1'b1; m_code = 2'b00; end
        endcase
        if (op == 4'h1) begin
            for (int unsigned g = 0; g < gap; g++) begin
                hold = 1'($urandom_range(0, 1));
                #1;
                check("imm_wait_ready", instr_ready, 1);
                check("imm_wait_issue", issue, 0);
                tick();
            end
            instr_valid = 1'b1;
            instr_data  = imm;
            tick();
            instr_valid = 1'b0;
            m_data = imm;
        end
        for (int unsigned h = 0; h < holds; h++) begin
            hold = 1'b1;
            #1;
            check("held_issue", issue, 0);
            check("held_mi", MemInstruction, 0);
            check("held_ready", instr_ready, 0);
            tick();
        end
        hold = 1'b0;
        #1;
        check("issue", issue, 1);
        check("mi", MemInstruction, m_code);
        check("selx", SelX, m_x);
        check("sely", SelY, m_y);
        check("selz", SelZ, m_z);
        check("memdata", MemData, m_data);
        check("illegal", illegal, m_ill);
        tick();
        m_cnt++;
        check("count", instr_count, m_cnt % (1 << CNT_W));
        check("count_small", s_count, m_cnt % 16);
        check("post_issue", issue, 0);
        check("post_mi", MemInstruction, 0);
    endtask

    initial begin
        logic [31:0] w, imm;
        int unsigned r;

        apply_reset();

        send(32'h2500FFFE, 0, 0, 0);
        send(32'h13000000, 32'hDEADBEEF, 3, 0);
        send(32'h30C80000, 0, 0, 4);
        send(32'h7ABCDEF0, 0, 0, 0);
        send(32'h21007FFF, 0, 0, 1);
        check("illegal_sticky", illegal, 1);
        idle(2);

        // Reset while waiting for the LDI immediate: nothing must issue.
        instr_valid = 1'b1;
        instr_data  = 32'h16000000;
        tick();
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_cleared("reset_imm");
        tick();
        rst = 1'b1;
        tick();
        check("reset_imm_noissue", issue, 0);
        send(32'h24001234, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            w = $urandom;
            w[31:28] = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            imm = $urandom;
            send(w, imm, $urandom_range(0, 3), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
